// File: rtl/prores_vlc_pkg.sv
// Shared definitions for the ProRes AC coefficient entropy encoder:
// default widths, adaptive codebook tables, codebook field extraction and FSM states.
package prores_vlc_pkg;

    localparam int unsigned COEFF_W_DEF = 20;
    localparam int unsigned CODE_W_DEF  = 48;
    localparam int unsigned LEN_W_DEF   = 6;
    localparam int unsigned RUN_W_DEF   = 12;

    localparam logic [3:0] PREV_RUN_INIT   = 4'd4;
    localparam logic [3:0] PREV_LEVEL_INIT = 4'd2;

    localparam logic [7:0] RUN_TO_CB [16] = '{
        8'h06, 8'h06, 8'h05, 8'h05, 8'h04, 8'h29, 8'h29, 8'h29,
        8'h29, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C
    };

    localparam logic [7:0] LEVEL_TO_CB [10] = '{
        8'h04, 8'h0A, 8'h05, 8'h06, 8'h04, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LEVEL
    } enc_state_e;

    function automatic logic [2:0] cb_rice(input logic [7:0] cb);
        return cb[7:5];
    endfunction

    function automatic logic [2:0] cb_expo(input logic [7:0] cb);
        return cb[4:2];
    endfunction

    function automatic logic [1:0] cb_switch(input logic [7:0] cb);
        return cb[1:0];
    endfunction

endpackage

// File: rtl/vlc_codeword_gen.sv
// Combinational adaptive Rice / exp-Golomb codeword generator.
// Output bits are right-aligned; leading zeros of the code are implied by the length.
module vlc_codeword_gen
    import prores_vlc_pkg::*;
#(
    parameter int unsigned VAL_W  = 21,
    parameter int unsigned CODE_W = 48,
    parameter int unsigned LEN_W  = 6
) (
    input  logic [7:0]        cb,
    input  logic [VAL_W-1:0]  value,
    output logic [CODE_W-1:0] bits,
    output logic [LEN_W-1:0]  len
);

    logic [2:0]       rice;
    logic [2:0]       expo;
    logic [1:0]       sw;
    logic [VAL_W+1:0] val_ext;
    logic [VAL_W+1:0] one_ext;
    logic [VAL_W+1:0] first;
    logic [VAL_W+1:0] rice_one;
    logic [VAL_W+1:0] v;
    int unsigned      e_u;
    int unsigned      q_u;

    always_comb begin
        rice     = cb_rice(cb);
        expo     = cb_expo(cb);
        sw       = cb_switch(cb);
        val_ext  = {2'b00, value};
        one_ext  = (VAL_W+2)'(1);
        first    = ({{VAL_W{1'b0}}, sw} + one_ext) << rice;
        rice_one = one_ext << rice;
        v        = '0;
        e_u      = 0;
        q_u      = 0;
        bits     = '0;
        len      = '0;
        if (val_ext < first) begin
            // Rice: unary quotient terminated by a 1, then rice remainder bits
            q_u  = 32'(val_ext >> rice);
            bits = CODE_W'(rice_one | (val_ext & (rice_one - one_ext)));
            len  = LEN_W'(q_u + 1 + 32'(rice));
        end else begin
            v = val_ext - first + (one_ext << expo);
            for (int unsigned i = 0; i < VAL_W + 2; i++) begin
                if (v[i]) begin
                    e_u = i;
                end
            end
            bits = CODE_W'(v);
            len  = LEN_W'(2 * e_u + 1 + 32'(sw) - 32'(expo));
        end
    end

endmodule

// File: rtl/entropy_encode_ac_coefficients.sv
// AC coefficient entropy encoder: counts zero runs and emits a run codeword
// followed by a level+sign codeword for each nonzero coefficient.
module entropy_encode_ac_coefficients
    import prores_vlc_pkg::*;
#(
    parameter int unsigned COEFF_W = COEFF_W_DEF,
    parameter int unsigned CODE_W  = CODE_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned RUN_W   = RUN_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               slice_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_bits,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_is_level
);

    localparam int unsigned VAL_W = COEFF_W + 1;

    enc_state_e        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [3:0]        prev_run_q, prev_run_d;
    logic [3:0]        prev_level_q, prev_level_d;
    logic [VAL_W-1:0]  abs_q, abs_d;
    logic              sign_q, sign_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] out_bits_q, out_bits_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;
    logic              out_is_level_q, out_is_level_d;

    logic [RUN_W-1:0]  run_eff;
    logic [3:0]        prev_run_eff;
    logic [3:0]        prev_level_eff;
    logic [VAL_W-1:0]  coeff_ext;
    logic [VAL_W-1:0]  coeff_abs;
    logic [7:0]        gen_cb;
    logic [VAL_W-1:0]  gen_value;
    logic [CODE_W-1:0] gen_bits;
    logic [LEN_W-1:0]  gen_len;

    vlc_codeword_gen #(
        .VAL_W  (VAL_W),
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W)
    ) u_gen (
        .cb    (gen_cb),
        .value (gen_value),
        .bits  (gen_bits),
        .len   (gen_len)
    );

    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        prev_run_d     = prev_run_q;
        prev_level_d   = prev_level_q;
        abs_d          = abs_q;
        sign_d         = sign_q;
        out_valid_d    = out_valid_q;
        out_bits_d     = out_bits_q;
        out_len_d      = out_len_q;
        out_is_level_d = out_is_level_q;

        // A slice start resets the adaptation context before the coefficient is processed
        run_eff        = slice_start ? '0 : run_q;
        prev_run_eff   = slice_start ? PREV_RUN_INIT : prev_run_q;
        prev_level_eff = slice_start ? PREV_LEVEL_INIT : prev_level_q;
        coeff_ext      = {in_coeff[COEFF_W-1], in_coeff};
        coeff_abs      = in_coeff[COEFF_W-1] ? (~coeff_ext + VAL_W'(1)) : coeff_ext;

        // The single generator serves the run code in IDLE and the level code otherwise
        if (state_q == ST_IDLE) begin
            gen_cb    = RUN_TO_CB[prev_run_eff];
            gen_value = VAL_W'(run_eff);
        end else begin
            gen_cb    = LEVEL_TO_CB[prev_level_q];
            gen_value = abs_q - VAL_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    prev_run_d   = prev_run_eff;
                    prev_level_d = prev_level_eff;
                    if (coeff_abs == '0) begin
                        run_d = (run_eff == '1) ? run_eff : run_eff + RUN_W'(1);
                    end else begin
                        run_d          = run_eff;
                        abs_d          = coeff_abs;
                        sign_d         = in_coeff[COEFF_W-1];
                        out_bits_d     = gen_bits;
                        out_len_d      = gen_len;
                        out_is_level_d = 1'b0;
                        out_valid_d    = 1'b1;
                        state_d        = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    prev_run_d     = (run_q > RUN_W'(15)) ? 4'd15 : run_q[3:0];
                    run_d          = '0;
                    out_bits_d     = {gen_bits[CODE_W-2:0], sign_q};
                    out_len_d      = gen_len + LEN_W'(1);
                    out_is_level_d = 1'b1;
                    state_d        = ST_LEVEL;
                end
            end
            ST_LEVEL: begin
                if (out_ready) begin
                    prev_level_d = (abs_q > VAL_W'(9)) ? 4'd9 : abs_q[3:0];
                    out_valid_d  = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            run_q          <= '0;
            prev_run_q     <= PREV_RUN_INIT;
            prev_level_q   <= PREV_LEVEL_INIT;
            abs_q          <= '0;
            sign_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_bits_q     <= '0;
            out_len_q      <= '0;
            out_is_level_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            prev_run_q     <= prev_run_d;
            prev_level_q   <= prev_level_d;
            abs_q          <= abs_d;
            sign_q         <= sign_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_bits_q     <= out_bits_d;
            out_len_q      <= out_len_d;
            out_is_level_q <= out_is_level_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_bits     = out_bits_q;
    assign out_len      = out_len_q;
    assign out_is_level = out_is_level_q;

endmodule

// File: tb/tb_entropy_encode_ac_coefficients.sv
// Directed bench for entropy_encode_ac_coefficients with hand-computed codewords.
module tb_entropy_encode_ac_coefficients;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        slice_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_coeff = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_bits;
    logic [5:0]  out_len;
    logic        out_is_level;

    int n_cmp  = 0;
    int n_fail = 0;

    entropy_encode_ac_coefficients #(
        .COEFF_W (20),
        .CODE_W  (48),
        .LEN_W   (6),
        .RUN_W   (12)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .slice_start  (slice_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_coeff     (in_coeff),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bits     (out_bits),
        .out_len      (out_len),
        .out_is_level (out_is_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the coefficient is accepted
    task automatic send(input string tag, input logic [19:0] c, input logic ss);
        int unsigned n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid    = 1'b1;
        in_coeff    = c;
        slice_start = ss;
        @(negedge clk);
        in_valid    = 1'b0;
        slice_start = 1'b0;
        in_coeff    = '0;
    endtask

    task automatic expect_cw(input string tag, input logic [47:0] b, input logic [5:0] l,
                             input logic lv);
        int unsigned n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_bits"}, 64'(out_bits), 64'(b));
        chk({tag, "_len"}, 64'(out_len), 64'(l));
        chk({tag, "_is_level"}, 64'(out_is_level), 64'(lv));
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_bits", 64'(out_bits), 64'(0));
        chk("rst_out_len", 64'(out_len), 64'(0));
        chk("rst_is_level", 64'(out_is_level), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'(1));

        // Positive level: run 2 (cb 04) then level 3 (cb 05)
        send("pos0", 20'd0, 1'b1);
        send("pos1", 20'd0, 1'b0);
        chk("pos_no_out_for_zeros", 64'(out_valid), 64'(0));
        send("pos2", 20'd3, 1'b0);
        chk("pos_in_ready_busy", 64'(in_ready), 64'(0));
        expect_cw("pos_run", 48'h3, 6'd2, 1'b0);
        expect_cw("pos_lvl", 48'h4, 6'd4, 1'b1);

        // Adaptation: prev_run=2 -> cb 05, prev_level=3 -> cb 06
        send("adp", 20'd1, 1'b0);
        expect_cw("adp_run", 48'h1, 6'd1, 1'b0);
        expect_cw("adp_lvl", 48'h2, 6'd2, 1'b1);
        chk("adp_idle", 64'(out_valid), 64'(0));

        // Negative level in a fresh slice
        send("neg0", 20'd0, 1'b1);
        send("neg1", 20'd0, 1'b0);
        send("neg2", 20'hFFFFD, 1'b0);
        expect_cw("neg_run", 48'h3, 6'd2, 1'b0);
        expect_cw("neg_lvl", 48'h5, 6'd4, 1'b1);

        // Backpressure with a stray in_valid that must be ignored
        out_ready = 1'b0;
        send("bp0", 20'd0, 1'b1);
        send("bp1", 20'd0, 1'b0);
        send("bp2", 20'd3, 1'b0);
        in_valid = 1'b1;
        in_coeff = 20'd5;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_bits", 64'(out_bits), 64'(48'h3));
            chk("bp_len", 64'(out_len), 64'(6'd2));
            chk("bp_is_level", 64'(out_is_level), 64'(0));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_coeff = '0;
        out_ready = 1'b1;
        expect_cw("bp_run", 48'h3, 6'd2, 1'b0);
        expect_cw("bp_lvl", 48'h4, 6'd4, 1'b1);
        chk("bp_no_dup", 64'(out_valid), 64'(0));

        // Trailing zeros then slice restart with coefficient 1
        for (int i = 0; i < 7; i++) begin
            send("tz", 20'd0, 1'b0);
            chk("tz_no_out", 64'(out_valid), 64'(0));
        end
        send("rs", 20'd1, 1'b1);
        expect_cw("rs_run", 48'h1, 6'd1, 1'b0);
        expect_cw("rs_lvl", 48'h2, 6'd2, 1'b1);

        // Reset while a level codeword is pending
        send("mr0", 20'd0, 1'b1);
        send("mr1", 20'd0, 1'b0);
        send("mr2", 20'd3, 1'b0);
        expect_cw("mr_run", 48'h3, 6'd2, 1'b0);
        chk("mr_in_level", 64'(out_is_level), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("mr_async_valid", 64'(out_valid), 64'(0));
        chk("mr_async_in_ready", 64'(in_ready), 64'(0));
        chk("mr_async_bits", 64'(out_bits), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send("pr0", 20'd0, 1'b0);
        send("pr1", 20'd0, 1'b0);
        send("pr2", 20'd3, 1'b0);
        expect_cw("pr_run", 48'h3, 6'd2, 1'b0);
        expect_cw("pr_lvl", 48'h4, 6'd4, 1'b1);

        // Most negative coefficient: abs = 2^19, level value 2^19-1 under cb 05
        send("mn", 20'h80000, 1'b1);
        expect_cw("mn_run", 48'h1, 6'd1, 1'b0);
        expect_cw("mn_lvl", 48'hFFFFF, 6'd38, 1'b1);

        // Run saturation: 4100 zeros clamp to 4095, coded with cb 06
        for (int i = 0; i < 4100; i++) begin
            send("sat_z", 20'd0, 1'b0);
        end
        chk("sat_no_out", 64'(out_valid), 64'(0));
        send("sat", 20'd1, 1'b0);
        expect_cw("sat_run", 48'hFFE, 6'd24, 1'b0);
        expect_cw("sat_lvl", 48'h8, 6'd4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
